// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: width, FSM encodings
// and a two's-complement magnitude helper.
package div_pkg;

  localparam int N_BITS = 32;
  localparam int CNT_W  = $clog2(N_BITS) + 1;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_DIVIDE = 2'd1,
    DIV_FIX    = 2'd2
  } div_state_e;

  // Unsigned magnitude of a two's-complement value; 0x80000000 maps to 2^31,
  // which is exactly what the unsigned core needs for the overflow case.
  function automatic logic [N_BITS-1:0] mag(input logic [N_BITS-1:0] x);
    return x[N_BITS-1] ? ((~x) + N_BITS'(1)) : x;
  endfunction

endpackage

// File: rtl/div_if.sv
// Operand/result bundle between the control unit (master) and the divider (slave).
interface div_if
  import div_pkg::*;
();
  logic [N_BITS-1:0] srcA;
  logic [N_BITS-1:0] srcB;
  logic              divCtrl;
  logic [N_BITS-1:0] hi;
  logic [N_BITS-1:0] lo;
  logic              busy;
  logic              done;
  logic              divZero;

  modport master (
    output srcA, srcB, divCtrl,
    input  hi, lo, busy, done, divZero
  );

  modport slave (
    input  srcA, srcB, divCtrl,
    output hi, lo, busy, done, divZero
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step
  import div_pkg::*;
(
  input  logic [N_BITS-1:0] i_rem,
  input  logic [N_BITS-1:0] i_quo,
  input  logic [N_BITS-1:0] i_divisor,
  output logic [N_BITS-1:0] o_rem,
  output logic [N_BITS-1:0] o_quo
);

  logic [N_BITS:0] w_rem_sh;
  logic [N_BITS:0] w_trial;
  logic            w_neg;

  // Shift {rem,quo} left, trial-subtract one bit wider so the borrow is the sign.
  always_comb begin
    w_rem_sh = {i_rem, i_quo[N_BITS-1]};
    w_trial  = w_rem_sh - {1'b0, i_divisor};
    w_neg    = w_trial[N_BITS];
    o_rem    = w_neg ? w_rem_sh[N_BITS-1:0] : w_trial[N_BITS-1:0];
    o_quo    = {i_quo[N_BITS-2:0], ~w_neg};
  end

endmodule

// File: rtl/div.sv
// Sequential signed divider, MIPS div semantics: quotient to lo (truncated
// toward zero), remainder to hi (sign of dividend).
//
// state      | meaning
// DIV_IDLE   | waiting for divCtrl; divide-by-zero flagged here
// DIV_DIVIDE | one restoring step per clock, N_BITS steps
// DIV_FIX    | apply signs, write hi/lo, pulse done
module div
  import div_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  div_if.slave  bus
);

  div_state_e        r_state;
  div_state_e        w_next_state;
  logic [N_BITS-1:0] r_rem;
  logic [N_BITS-1:0] r_quo;
  logic [N_BITS-1:0] r_divisor;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign_q;
  logic              r_sign_r;
  logic [N_BITS-1:0] r_hi;
  logic [N_BITS-1:0] r_lo;
  logic              r_done;
  logic              r_div_zero;
  logic [N_BITS-1:0] w_rem_nxt;
  logic [N_BITS-1:0] w_quo_nxt;
  logic              w_last_step;

  div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  assign w_last_step = (r_cnt == CNT_W'(N_BITS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; a zero divisor never leaves IDLE.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      DIV_IDLE:   if (bus.divCtrl && (bus.srcB != '0)) w_next_state = DIV_DIVIDE;
      DIV_DIVIDE: if (w_last_step) w_next_state = DIV_FIX;
      DIV_FIX:    w_next_state = DIV_IDLE;
      default:    w_next_state = DIV_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        DIV_IDLE: begin
          if (bus.divCtrl) begin
            if (bus.srcB == '0) begin
              r_div_zero <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_quo      <= mag(bus.srcA);
              r_divisor  <= mag(bus.srcB);
              r_rem      <= '0;
              r_cnt      <= '0;
              r_sign_q   <= bus.srcA[N_BITS-1] ^ bus.srcB[N_BITS-1];
              r_sign_r   <= bus.srcA[N_BITS-1];
              r_div_zero <= 1'b0;
            end
          end
        end
        DIV_DIVIDE: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        DIV_FIX: begin
          r_lo   <= r_sign_q ? ((~r_quo) + N_BITS'(1)) : r_quo;
          r_hi   <= r_sign_r ? ((~r_rem) + N_BITS'(1)) : r_rem;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.busy    = (r_state != DIV_IDLE);
  assign bus.done    = r_done;
  assign bus.divZero = r_div_zero;

endmodule
